// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: sign/zero/upper/branch extension stored into a 2-entry FIFO skid buffer.
// Optional push counter output enabled by defining IMM_EXTEND_STATS_EN.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef IMM_EXTEND_STATS_EN
  output logic [15:0]      push_cnt_o,
`endif
  output logic [OUT_W-1:0] out_data_o
);

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // Both ready and valid come from the registered count only, so no path exists
  // from out_ready_i to in_ready_o.
  localparam int UP_SH = OUT_W - IN_W;

  logic [1:0]       r_count;
  logic [OUT_W-1:0] r_head;
  logic [OUT_W-1:0] r_tail;

  logic             w_push;
  logic             w_pop;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic [1:0]       w_count_nxt;
  logic [OUT_W-1:0] w_head_nxt;
  logic [OUT_W-1:0] w_tail_nxt;

  assign in_ready_o  = (r_count < 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign out_data_o  = r_head;
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  // Loop form keeps the sign fill legal when IN_W == OUT_W (zero fill bits).
  always_comb begin
    w_zext             = '0;
    w_zext[IN_W-1:0]   = data_i;
    w_sext             = w_zext;
    for (int i = IN_W; i < OUT_W; i++) w_sext[i] = data_i[IN_W-1];
  end

  always_comb begin
    w_ext = w_sext;
    case (mode_i)
      2'b00:   w_ext = w_sext;
      2'b01:   w_ext = w_zext;
      2'b10:   w_ext = w_zext << UP_SH;
      default: w_ext = w_sext << SHAMT;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (flush_i) begin
      w_count_nxt = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            w_head_nxt  = w_ext;
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          // Simultaneous push/pop replaces the head in place.
          if (w_push && w_pop) begin
            w_head_nxt = w_ext;
          end else if (w_push) begin
            w_tail_nxt  = w_ext;
            w_count_nxt = 2'd2;
          end else if (w_pop) begin
            w_count_nxt = 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            w_head_nxt  = r_tail;
            w_count_nxt = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

`ifdef IMM_EXTEND_STATS_EN
  logic [15:0] r_push_cnt;

  // Counts pushes that are actually stored; a push discarded by flush is not counted.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_push_cnt <= 16'd0;
    end else if (w_push && !flush_i) begin
      r_push_cnt <= r_push_cnt + 16'd1;
    end
  end

  assign push_cnt_o = r_push_cnt;
`endif

endmodule
